mem_access_stage: RTL and testbench

Memory stage of the pipelined OTTER core; sits directly downstream of the execute stage and consumes its pipeline-register outputs. Issues loads and stores to data memory over a req/ack handshake and stalls upstream while an access is outstanding. Aligns and extends load data, then registers results for writeback.

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/mem_load_align.sv | 25 ++
 rtl/mem_access_stage.sv | 202 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the OTTER memory stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MSZ_BYTE = 2'b00,
    MSZ_HALF = 2'b01,
    MSZ_WORD = 2'b10,
    MSZ_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic {
    MS_IDLE     = 1'b0,
    MS_WAIT_ACK = 1'b1
  } mem_state_t;

  // Half needs addr[0]=0; word (and the reserved size, treated as word) needs addr[1:0]=0.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr);
    case (size)
      MSZ_BYTE: return 1'b0;
      MSZ_HALF: return addr[0];
      default:  return addr != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data aligner: shifts the addressed lane down, truncates to the access
// size and sign- or zero-extends to 32 bits.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  mem_size_t   size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  // Lane select then extend.
  always_comb begin
    sh = rdata_i >> {addr_i, 3'b000};
    case (size_i)
      MSZ_BYTE: data_o = {{24{~uns_i & sh[7]}},  sh[7:0]};
      MSZ_HALF: data_o = {{16{~uns_i & sh[15]}}, sh[15:0]};
      default:  data_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// OTTER memory stage: issues loads/stores over a req/ack bus, stalls upstream
// while an access is outstanding, and registers results for writeback.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned accesses are not issued and
// retire immediately with MEM_MISALIGN=1 and MEM_REGWRITE=0.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              MEMORY_CLOCK,
  input  logic              MEMORY_RESET,
  input  logic              EXEC_VALID,
  input  logic [ADDR_W-1:0] EXEC_PC_4,
  input  logic [DATA_W-1:0] EXEC_ALU_RESULT,
  input  logic [DATA_W-1:0] EXEC_RS2,
  input  logic [1:0]        EXEC_RF_WR_SEL,
  input  logic              EXEC_REGWRITE,
  input  logic              EXEC_MEMWRITE,
  input  logic              EXEC_MEMREAD2,
  input  logic [1:0]        EXEC_SIZE,
  input  logic              EXEC_UNSIGNED,
  output logic              MEM_STALL,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [ADDR_W-1:0] DMEM_ADDR,
  output logic [DATA_W-1:0] DMEM_WDATA,
  output logic [3:0]        DMEM_BE,
  input  logic [DATA_W-1:0] DMEM_RDATA,
  input  logic              DMEM_ACK,
  output logic              MEM_VALID,
  output logic [ADDR_W-1:0] MEM_PC_4,
  output logic [DATA_W-1:0] MEM_ALU_RESULT,
  output logic [DATA_W-1:0] MEM_LOAD_DATA,
  output logic [1:0]        MEM_RF_WR_SEL,
  output logic              MEM_REGWRITE,
  output logic              MEM_MISALIGN
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [3:0]        req_be_q, req_be_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic              req_we_q, req_we_d;
  mem_size_t         req_size_q, req_size_d;
  logic              req_uns_q, req_uns_d;
  logic [1:0]        req_off_q, req_off_d;

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] ld_q, ld_d;
  logic [1:0]        rfsel_q, rfsel_d;
  logic              rw_q, rw_d;
  logic              mis_q, mis_d;

  mem_size_t         sz;
  logic [1:0]        off;
  logic              memop, mis, trap;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] aligned;

  assign sz    = mem_size_t'(EXEC_SIZE);
  assign off   = EXEC_ALU_RESULT[1:0];
  assign memop = EXEC_MEMWRITE | EXEC_MEMREAD2;
  assign mis   = is_misaligned(sz, off);
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap  = EXEC_VALID & memop & mis;
`else
  assign trap  = 1'b0;
`endif

  // Byte-lane enables and lane-replicated store data for the incoming op.
  always_comb begin
    case (sz)
      MSZ_BYTE: begin be_c = 4'b0001 << off;             wdata_c = {4{EXEC_RS2[7:0]}};  end
      MSZ_HALF: begin be_c = 4'b0011 << {off[1], 1'b0};  wdata_c = {2{EXEC_RS2[15:0]}}; end
      default:  begin be_c = 4'b1111;                    wdata_c = EXEC_RS2;            end
    endcase
  end

  // Latched request lanes drive the aligner when the ack arrives.
  mem_load_align u_align (
    .rdata_i (DMEM_RDATA),
    .addr_i  (req_off_q),
    .size_i  (req_size_q),
    .uns_i   (req_uns_q),
    .data_o  (aligned)
  );

  // Next-state, stall and writeback-register update. While stalled the
  // upstream holds EXEC_*, so pass-through fields are taken at retire time.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_be_d    = req_be_q;
    req_wdata_d = req_wdata_q;
    req_we_d    = req_we_q;
    req_size_d  = req_size_q;
    req_uns_d   = req_uns_q;
    req_off_d   = req_off_q;
    valid_d     = 1'b0;
    pc4_d       = pc4_q;
    alu_d       = alu_q;
    ld_d        = ld_q;
    rfsel_d     = rfsel_q;
    rw_d        = rw_q;
    mis_d       = mis_q;
    MEM_STALL   = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (EXEC_VALID) begin
          if (memop && !trap) begin
            MEM_STALL   = 1'b1;
            state_d     = MS_WAIT_ACK;
            req_addr_d  = {EXEC_ALU_RESULT[ADDR_W-1:2], 2'b00};
            req_be_d    = be_c;
            req_wdata_d = wdata_c;
            req_we_d    = EXEC_MEMWRITE;
            req_size_d  = sz;
            req_uns_d   = EXEC_UNSIGNED;
            req_off_d   = off;
          end else begin
            valid_d = 1'b1;
            pc4_d   = EXEC_PC_4;
            alu_d   = EXEC_ALU_RESULT;
            rfsel_d = EXEC_RF_WR_SEL;
            rw_d    = EXEC_REGWRITE & ~trap;
            ld_d    = '0;
            mis_d   = trap;
          end
        end
      end
      MS_WAIT_ACK: begin
        MEM_STALL = ~DMEM_ACK;
        if (DMEM_ACK) begin
          state_d = MS_IDLE;
          valid_d = 1'b1;
          pc4_d   = EXEC_PC_4;
          alu_d   = EXEC_ALU_RESULT;
          rfsel_d = EXEC_RF_WR_SEL;
          rw_d    = EXEC_REGWRITE;
          ld_d    = req_we_q ? '0 : aligned;
          mis_d   = is_misaligned(req_size_q, req_off_q);
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge MEMORY_CLOCK) begin
    if (!MEMORY_RESET) begin
      state_q     <= MS_IDLE;
      req_addr_q  <= '0;
      req_be_q    <= '0;
      req_wdata_q <= '0;
      req_we_q    <= 1'b0;
      req_size_q  <= MSZ_BYTE;
      req_uns_q   <= 1'b0;
      req_off_q   <= '0;
      valid_q     <= 1'b0;
      pc4_q       <= '0;
      alu_q       <= '0;
      ld_q        <= '0;
      rfsel_q     <= '0;
      rw_q        <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_be_q    <= req_be_d;
      req_wdata_q <= req_wdata_d;
      req_we_q    <= req_we_d;
      req_size_q  <= req_size_d;
      req_uns_q   <= req_uns_d;
      req_off_q   <= req_off_d;
      valid_q     <= valid_d;
      pc4_q       <= pc4_d;
      alu_q       <= alu_d;
      ld_q        <= ld_d;
      rfsel_q     <= rfsel_d;
      rw_q        <= rw_d;
      mis_q       <= mis_d;
    end
  end

  assign DMEM_REQ       = (state_q == MS_WAIT_ACK);
  assign DMEM_WE        = DMEM_REQ & req_we_q;
  assign DMEM_ADDR      = req_addr_q;
  assign DMEM_BE        = req_be_q;
  assign DMEM_WDATA     = req_wdata_q;
  assign MEM_VALID      = valid_q;
  assign MEM_PC_4       = pc4_q;
  assign MEM_ALU_RESULT = alu_q;
  assign MEM_LOAD_DATA  = ld_q;
  assign MEM_RF_WR_SEL  = rfsel_q;
  assign MEM_REGWRITE   = rw_q;
  assign MEM_MISALIGN   = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage with a transaction-level
// reference model; honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ev, rw_i, mw, mr, uns_i, stall, req, we, ack;
  logic [31:0] pc4_i, alu_i, rs2_i, daddr, wdata, rdata;
  logic [1:0]  rfsel_i, size_i;
  logic [3:0]  be;
  logic        mvalid, mrw, mmis;
  logic [31:0] mpc4, malu, mld;
  logic [1:0]  mrfsel;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_ld, obs_be, obs_addr, obs_wd;
  logic        last_mis, last_rw;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .MEMORY_CLOCK(clk), .MEMORY_RESET(rst_n),
    .EXEC_VALID(ev), .EXEC_PC_4(pc4_i), .EXEC_ALU_RESULT(alu_i), .EXEC_RS2(rs2_i),
    .EXEC_RF_WR_SEL(rfsel_i), .EXEC_REGWRITE(rw_i), .EXEC_MEMWRITE(mw),
    .EXEC_MEMREAD2(mr), .EXEC_SIZE(size_i), .EXEC_UNSIGNED(uns_i),
    .MEM_STALL(stall), .DMEM_REQ(req), .DMEM_WE(we), .DMEM_ADDR(daddr),
    .DMEM_WDATA(wdata), .DMEM_BE(be), .DMEM_RDATA(rdata), .DMEM_ACK(ack),
    .MEM_VALID(mvalid), .MEM_PC_4(mpc4), .MEM_ALU_RESULT(malu),
    .MEM_LOAD_DATA(mld), .MEM_RF_WR_SEL(mrfsel), .MEM_REGWRITE(mrw),
    .MEM_MISALIGN(mmis)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // op: 0 none, 1 load, 2 store, 3 load+store (acts as store). d = ack wait cycles.
  task automatic run_txn(input int op, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rd, input logic [1:0] sz, input logic uns,
                         input int d);
    logic memop, st, mis, trap, rw;
    logic [1:0]  off, rfsel;
    logic [3:0]  ebe;
    logic [31:0] pc4, ewd, sh, eld;
    pc4 = $urandom; rfsel = 2'($urandom); rw = 1'($urandom);
    off = addr[1:0];
    memop = (op != 0);
    st = (op >= 2);
    mis = memop && ((sz == 2'd1 && off[0]) || (sz[1] && off != 2'd0));
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = mis;
`endif
    case (sz)
      2'd0: begin ebe = 4'b0001 << off; ewd = {24'd0, rs2[7:0]} * 32'h0101_0101; end
      2'd1: begin ebe = 4'b0011 << (off & 2'b10); ewd = {16'd0, rs2[15:0]} * 32'h0001_0001; end
      default: begin ebe = 4'b1111; ewd = rs2; end
    endcase
    sh = rd >> (8 * off);
    case (sz)
      2'd0: begin eld = sh & 32'hFF; if (!uns && sh[7]) eld |= 32'hFFFF_FF00; end
      2'd1: begin eld = sh & 32'hFFFF; if (!uns && sh[15]) eld |= 32'hFFFF_0000; end
      default: eld = sh;
    endcase
    if (!memop || st || trap) eld = 32'd0;

    ev = 1'b1; pc4_i = pc4; alu_i = addr; rs2_i = rs2; rfsel_i = rfsel; rw_i = rw;
    mw = (op >= 2); mr = (op == 1 || op == 3); size_i = sz; uns_i = uns;
    #1;
    chk("stall_accept", stall, memop && !trap);
    chk("req_idle", req, 1'b0);
    if (memop && !trap) begin
      @(posedge clk); @(negedge clk);
      for (int i = 0; i <= d; i++) begin
        ack = (i == d);
        rdata = (i == d) ? rd : $urandom;
        #1;
        chk("req_wait", req, 1'b1);
        chk("we_wait", we, st);
        chk("addr_wait", daddr, {addr[31:2], 2'b00});
        chk("be_wait", be, ebe);
        chk("wdata_wait", wdata, ewd);
        chk("stall_wait", stall, i != d);
        chk("valid_wait", mvalid, 1'b0);
        if (i < d) begin @(posedge clk); @(negedge clk); end
      end
      obs_be = {28'd0, be}; obs_addr = daddr; obs_wd = wdata;
    end
    @(posedge clk); @(negedge clk);
    ack = 1'b0; ev = 1'b0;
    #1;
    chk("valid_retire", mvalid, 1'b1);
    chk("pc4_retire", mpc4, pc4);
    chk("alu_retire", malu, addr);
    chk("ld_retire", mld, eld);
    chk("rfsel_retire", mrfsel, rfsel);
    chk("rw_retire", mrw, rw && !trap);
    chk("mis_retire", mmis, mis);
    chk("req_retire", req, 1'b0);
    last_ld = mld; last_mis = mmis; last_rw = mrw;
    @(posedge clk); @(negedge clk);
    #1;
    chk("valid_bubble", mvalid, 1'b0);
    chk("alu_hold", malu, addr);
  endtask

  initial begin
    rst_n = 1'b0; ev = 0; pc4_i = 0; alu_i = 0; rs2_i = 0; rfsel_i = 0; rw_i = 0;
    mw = 0; mr = 0; size_i = 0; uns_i = 0; ack = 0; rdata = 0;
    obs_be = 0; obs_addr = 0; obs_wd = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", mvalid, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_alu", malu, 32'd0);
    chk("rst_ld", mld, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    // Directed cases.
    run_txn(0, 32'h1234, 32'h0, 32'h0, 2'd2, 1'b0, 0);
    chk("tp_nomem_alu", malu, 32'h1234);
    run_txn(2, 32'h103, 32'hAABB_CCDD, 32'h0, 2'd0, 1'b0, 3);
    chk("tp_sb_addr", obs_addr, 32'h100);
    chk("tp_sb_be", obs_be, 32'h8);
    chk("tp_sb_wd", obs_wd, 32'hDDDD_DDDD);
    run_txn(1, 32'h202, 32'h0, 32'h8001_7FFF, 2'd1, 1'b0, 0);
    chk("tp_lh_be", obs_be, 32'hC);
    chk("tp_lh_s", last_ld, 32'hFFFF_8001);
    run_txn(1, 32'h202, 32'h0, 32'h8001_7FFF, 2'd1, 1'b1, 0);
    chk("tp_lh_u", last_ld, 32'h0000_8001);
    run_txn(1, 32'h001, 32'h0, 32'h0000_8000, 2'd0, 1'b0, 1);
    chk("tp_lb_s", last_ld, 32'hFFFF_FF80);
    run_txn(1, 32'h001, 32'h0, 32'h0000_8000, 2'd0, 1'b1, 2);
    chk("tp_lb_u", last_ld, 32'h0000_0080);
    obs_be = 0; obs_addr = 0;
    run_txn(1, 32'h006, 32'h0, 32'h1122_3344, 2'd2, 1'b0, 1);
    chk("tp_lw_mis", last_mis, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("tp_lw_trap_rw", last_rw, 1'b0);
    chk("tp_lw_trap_noreq", obs_be, 32'h0);
`else
    chk("tp_lw_be", obs_be, 32'hF);
    chk("tp_lw_addr", obs_addr, 32'h004);
`endif

    // Reset while waiting for an ack, then a stray ack in IDLE.
    ev = 1; pc4_i = 32'h55; alu_i = 32'h40; mr = 1; mw = 0; size_i = 2'd2; rw_i = 1;
    @(posedge clk); @(negedge clk);
    #1 chk("rstw_req_before", req, 1'b1);
    rst_n = 1'b0; ev = 1'b0;
    @(posedge clk); @(negedge clk);
    #1;
    chk("rstw_req", req, 1'b0);
    chk("rstw_we", we, 1'b0);
    chk("rstw_valid", mvalid, 1'b0);
    chk("rstw_alu", malu, 32'd0);
    chk("rstw_pc4", mpc4, 32'd0);
    chk("rstw_rfsel", mrfsel, 2'd0);
    chk("rstw_rw", mrw, 1'b0);
    chk("rstw_mis", mmis, 1'b0);
    rst_n = 1'b1; ack = 1'b1; rdata = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    ack = 1'b0;
    #1;
    chk("stray_ack_valid", mvalid, 1'b0);
    chk("stray_ack_req", req, 1'b0);
    @(posedge clk); @(negedge clk);
    #1 chk("stray_ack_valid2", mvalid, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 200; n++)
      run_txn(int'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
              2'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
